// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block constants, FSM state encoding and byte-slice helper
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

    // Byte 0 is the most significant byte (row 0, col 0, column-major order).
    function automatic logic [7:0] aes_byte(input logic [AES_BLOCK_W-1:0] blk, input int idx);
        return blk[AES_BLOCK_W-1-8*idx -: 8];
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational AES inverse S-box lookup
module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Full 256-entry inverse substitution table.
    always_comb begin
        out_byte = 8'h00;
        case (in_byte)
            8'h00: out_byte = 8'h52; 8'h01: out_byte = 8'h09; 8'h02: out_byte = 8'h6a; 8'h03: out_byte = 8'hd5; 8'h04: out_byte = 8'h30; 8'h05: out_byte = 8'h36; 8'h06: out_byte = 8'ha5; 8'h07: out_byte = 8'h38;
            8'h08: out_byte = 8'hbf; 8'h09: out_byte = 8'h40; 8'h0a: out_byte = 8'ha3; 8'h0b: out_byte = 8'h9e; 8'h0c: out_byte = 8'h81; 8'h0d: out_byte = 8'hf3; 8'h0e: out_byte = 8'hd7; 8'h0f: out_byte = 8'hfb;
            8'h10: out_byte = 8'h7c; 8'h11: out_byte = 8'he3; 8'h12: out_byte = 8'h39; 8'h13: out_byte = 8'h82; 8'h14: out_byte = 8'h9b; 8'h15: out_byte = 8'h2f; 8'h16: out_byte = 8'hff; 8'h17: out_byte = 8'h87;
            8'h18: out_byte = 8'h34; 8'h19: out_byte = 8'h8e; 8'h1a: out_byte = 8'h43; 8'h1b: out_byte = 8'h44; 8'h1c: out_byte = 8'hc4; 8'h1d: out_byte = 8'hde; 8'h1e: out_byte = 8'he9; 8'h1f: out_byte = 8'hcb;
            8'h20: out_byte = 8'h54; 8'h21: out_byte = 8'h7b; 8'h22: out_byte = 8'h94; 8'h23: out_byte = 8'h32; 8'h24: out_byte = 8'ha6; 8'h25: out_byte = 8'hc2; 8'h26: out_byte = 8'h23; 8'h27: out_byte = 8'h3d;
            8'h28: out_byte = 8'hee; 8'h29: out_byte = 8'h4c; 8'h2a: out_byte = 8'h95; 8'h2b: out_byte = 8'h0b; 8'h2c: out_byte = 8'h42; 8'h2d: out_byte = 8'hfa; 8'h2e: out_byte = 8'hc3; 8'h2f: out_byte = 8'h4e;
            8'h30: out_byte = 8'h08; 8'h31: out_byte = 8'h2e; 8'h32: out_byte = 8'ha1; 8'h33: out_byte = 8'h66; 8'h34: out_byte = 8'h28; 8'h35: out_byte = 8'hd9; 8'h36: out_byte = 8'h24; 8'h37: out_byte = 8'hb2;
            8'h38: out_byte = 8'h76; 8'h39: out_byte = 8'h5b; 8'h3a: out_byte = 8'ha2; 8'h3b: out_byte = 8'h49; 8'h3c: out_byte = 8'h6d; 8'h3d: out_byte = 8'h8b; 8'h3e: out_byte = 8'hd1; 8'h3f: out_byte = 8'h25;
            8'h40: out_byte = 8'h72; 8'h41: out_byte = 8'hf8; 8'h42: out_byte = 8'hf6; 8'h43: out_byte = 8'h64; 8'h44: out_byte = 8'h86; 8'h45: out_byte = 8'h68; 8'h46: out_byte = 8'h98; 8'h47: out_byte = 8'h16;
            8'h48: out_byte = 8'hd4; 8'h49: out_byte = 8'ha4; 8'h4a: out_byte = 8'h5c; 8'h4b: out_byte = 8'hcc; 8'h4c: out_byte = 8'h5d; 8'h4d: out_byte = 8'h65; 8'h4e: out_byte = 8'hb6; 8'h4f: out_byte = 8'h92;
            8'h50: out_byte = 8'h6c; 8'h51: out_byte = 8'h70; 8'h52: out_byte = 8'h48; 8'h53: out_byte = 8'h50; 8'h54: out_byte = 8'hfd; 8'h55: out_byte = 8'hed; 8'h56: out_byte = 8'hb9; 8'h57: out_byte = 8'hda;
            8'h58: out_byte = 8'h5e; 8'h59: out_byte = 8'h15; 8'h5a: out_byte = 8'h46; 8'h5b: out_byte = 8'h57; 8'h5c: out_byte = 8'ha7; 8'h5d: out_byte = 8'h8d; 8'h5e: out_byte = 8'h9d; 8'h5f: out_byte = 8'h84;
            8'h60: out_byte = 8'h90; 8'h61: out_byte = 8'hd8; 8'h62: out_byte = 8'hab; 8'h63: out_byte = 8'h00; 8'h64: out_byte = 8'h8c; 8'h65: out_byte = 8'hbc; 8'h66: out_byte = 8'hd3; 8'h67: out_byte = 8'h0a;
            8'h68: out_byte = 8'hf7; 8'h69: out_byte = 8'he4; 8'h6a: out_byte = 8'h58; 8'h6b: out_byte = 8'h05; 8'h6c: out_byte = 8'hb8; 8'h6d: out_byte = 8'hb3; 8'h6e: out_byte = 8'h45; 8'h6f: out_byte = 8'h06;
            8'h70: out_byte = 8'hd0; 8'h71: out_byte = 8'h2c; 8'h72: out_byte = 8'h1e; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'hca; 8'h75: out_byte = 8'h3f; 8'h76: out_byte = 8'h0f; 8'h77: out_byte = 8'h02;
            8'h78: out_byte = 8'hc1; 8'h79: out_byte = 8'haf; 8'h7a: out_byte = 8'hbd; 8'h7b: out_byte = 8'h03; 8'h7c: out_byte = 8'h01; 8'h7d: out_byte = 8'h13; 8'h7e: out_byte = 8'h8a; 8'h7f: out_byte = 8'h6b;
            8'h80: out_byte = 8'h3a; 8'h81: out_byte = 8'h91; 8'h82: out_byte = 8'h11; 8'h83: out_byte = 8'h41; 8'h84: out_byte = 8'h4f; 8'h85: out_byte = 8'h67; 8'h86: out_byte = 8'hdc; 8'h87: out_byte = 8'hea;
            8'h88: out_byte = 8'h97; 8'h89: out_byte = 8'hf2; 8'h8a: out_byte = 8'hcf; 8'h8b: out_byte = 8'hce; 8'h8c: out_byte = 8'hf0; 8'h8d: out_byte = 8'hb4; 8'h8e: out_byte = 8'he6; 8'h8f: out_byte = 8'h73;
            8'h90: out_byte = 8'h96; 8'h91: out_byte = 8'hac; 8'h92: out_byte = 8'h74; 8'h93: out_byte = 8'h22; 8'h94: out_byte = 8'he7; 8'h95: out_byte = 8'had; 8'h96: out_byte = 8'h35; 8'h97: out_byte = 8'h85;
            8'h98: out_byte = 8'he2; 8'h99: out_byte = 8'hf9; 8'h9a: out_byte = 8'h37; 8'h9b: out_byte = 8'he8; 8'h9c: out_byte = 8'h1c; 8'h9d: out_byte = 8'h75; 8'h9e: out_byte = 8'hdf; 8'h9f: out_byte = 8'h6e;
            8'ha0: out_byte = 8'h47; 8'ha1: out_byte = 8'hf1; 8'ha2: out_byte = 8'h1a; 8'ha3: out_byte = 8'h71; 8'ha4: out_byte = 8'h1d; 8'ha5: out_byte = 8'h29; 8'ha6: out_byte = 8'hc5; 8'ha7: out_byte = 8'h89;
            8'ha8: out_byte = 8'h6f; 8'ha9: out_byte = 8'hb7; 8'haa: out_byte = 8'h62; 8'hab: out_byte = 8'h0e; 8'hac: out_byte = 8'haa; 8'had: out_byte = 8'h18; 8'hae: out_byte = 8'hbe; 8'haf: out_byte = 8'h1b;
            8'hb0: out_byte = 8'hfc; 8'hb1: out_byte = 8'h56; 8'hb2: out_byte = 8'h3e; 8'hb3: out_byte = 8'h4b; 8'hb4: out_byte = 8'hc6; 8'hb5: out_byte = 8'hd2; 8'hb6: out_byte = 8'h79; 8'hb7: out_byte = 8'h20;
            8'hb8: out_byte = 8'h9a; 8'hb9: out_byte = 8'hdb; 8'hba: out_byte = 8'hc0; 8'hbb: out_byte = 8'hfe; 8'hbc: out_byte = 8'h78; 8'hbd: out_byte = 8'hcd; 8'hbe: out_byte = 8'h5a; 8'hbf: out_byte = 8'hf4;
            8'hc0: out_byte = 8'h1f; 8'hc1: out_byte = 8'hdd; 8'hc2: out_byte = 8'ha8; 8'hc3: out_byte = 8'h33; 8'hc4: out_byte = 8'h88; 8'hc5: out_byte = 8'h07; 8'hc6: out_byte = 8'hc7; 8'hc7: out_byte = 8'h31;
            8'hc8: out_byte = 8'hb1; 8'hc9: out_byte = 8'h12; 8'hca: out_byte = 8'h10; 8'hcb: out_byte = 8'h59; 8'hcc: out_byte = 8'h27; 8'hcd: out_byte = 8'h80; 8'hce: out_byte = 8'hec; 8'hcf: out_byte = 8'h5f;
            8'hd0: out_byte = 8'h60; 8'hd1: out_byte = 8'h51; 8'hd2: out_byte = 8'h7f; 8'hd3: out_byte = 8'ha9; 8'hd4: out_byte = 8'h19; 8'hd5: out_byte = 8'hb5; 8'hd6: out_byte = 8'h4a; 8'hd7: out_byte = 8'h0d;
            8'hd8: out_byte = 8'h2d; 8'hd9: out_byte = 8'he5; 8'hda: out_byte = 8'h7a; 8'hdb: out_byte = 8'h9f; 8'hdc: out_byte = 8'h93; 8'hdd: out_byte = 8'hc9; 8'hde: out_byte = 8'h9c; 8'hdf: out_byte = 8'hef;
            8'he0: out_byte = 8'ha0; 8'he1: out_byte = 8'he0; 8'he2: out_byte = 8'h3b; 8'he3: out_byte = 8'h4d; 8'he4: out_byte = 8'hae; 8'he5: out_byte = 8'h2a; 8'he6: out_byte = 8'hf5; 8'he7: out_byte = 8'hb0;
            8'he8: out_byte = 8'hc8; 8'he9: out_byte = 8'heb; 8'hea: out_byte = 8'hbb; 8'heb: out_byte = 8'h3c; 8'hec: out_byte = 8'h83; 8'hed: out_byte = 8'h53; 8'hee: out_byte = 8'h99; 8'hef: out_byte = 8'h61;
            8'hf0: out_byte = 8'h17; 8'hf1: out_byte = 8'h2b; 8'hf2: out_byte = 8'h04; 8'hf3: out_byte = 8'h7e; 8'hf4: out_byte = 8'hba; 8'hf5: out_byte = 8'h77; 8'hf6: out_byte = 8'hd6; 8'hf7: out_byte = 8'h26;
            8'hf8: out_byte = 8'he1; 8'hf9: out_byte = 8'h69; 8'hfa: out_byte = 8'h14; 8'hfb: out_byte = 8'h63; 8'hfc: out_byte = 8'h55; 8'hfd: out_byte = 8'h21; 8'hfe: out_byte = 8'h0c; 8'hff: out_byte = 8'h7d;
        endcase
    end

endmodule

// File: rtl/inv_subbytes_seq.sv
// rtl/inv_subbytes_seq.sv - serialized AES inverse SubBytes, LANES bytes per clock
module inv_subbytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_block,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_block,
    output logic                   busy
);

    localparam int NSTEPS = AES_NBYTES / LANES;
    localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEPS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    aes_state_e             state;
    aes_state_e             state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [AES_BLOCK_W-1:0] src_reg;
    logic [AES_BLOCK_W-1:0] res_reg;
    logic [7:0]             lane_in  [LANES];
    logic [7:0]             lane_out [LANES];
    logic                   last_step;

    assign last_step = (cnt == CNT_LAST);

    // Each lane reads the byte at cnt*LANES + lane from the captured state.
    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            assign lane_in[j] = aes_byte(src_reg, int'(cnt) * LANES + j);
            inv_sbox u_inv_sbox (
                .in_byte  (lane_in[j]),
                .out_byte (lane_out[j])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, step through BUSY, hold DONE until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_BUSY;
            ST_BUSY: if (last_step) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture on acceptance, write LANES substituted bytes per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            src_reg <= '0;
            res_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        src_reg <= in_block;
                        cnt     <= '0;
                    end
                end
                ST_BUSY: begin
                    for (int j = 0; j < LANES; j++) begin
                        res_reg[AES_BLOCK_W-1-8*(int'(cnt)*LANES+j) -: 8] <= lane_out[j];
                    end
                    if (!last_step) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // in_ready is masked during reset so nothing is offered while rst_n is low.
    assign in_ready  = rst_n && (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_BUSY) || (state == ST_DONE);
    assign out_block = res_reg;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// tb/tb_inv_subbytes_seq.sv - directed self-checking bench over LANES = 1, 2, 4, 16
module tb_inv_subbytes_seq;

    localparam logic [127:0] C1_IN    = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    localparam logic [127:0] C1_OUT   = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] SPOT_IN  = 128'h637c00ff160000000000000000000000;
    localparam logic [127:0] SPOT_OUT = 128'h0001527dff5252525252525252525252;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_block  [4];
    logic [127:0] out_block [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
            inv_subbytes_seq #(.LANES(L)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_block  (in_block[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_block (out_block[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Reference: inverse affine transform followed by GF(2^8) inversion (a^254).
    function automatic logic [7:0] inv_sbox_model(input logic [7:0] s);
        logic [7:0] t, sq, r;
        t  = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        sq = t; r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_model(input logic [127:0] blk);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox_model(blk[127-8*k -: 8]);
        return o;
    endfunction

    task automatic run_block(input int d, input logic [127:0] blk, input logic [127:0] exp,
                             input int lat_exp, input string tag);
        int edges;
        @(negedge clk);
        check({tag, "_in_ready"}, 128'(in_ready[d]), 128'd1);
        in_valid[d] = 1'b1;
        in_block[d] = blk;
        @(negedge clk);
        in_valid[d] = 1'b0;
        edges = 1;
        while (!out_valid[d] && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, 128'(edges - 1), 128'(lat_exp));
        check({tag, "_data"}, out_block[d], exp);
    endtask

    initial begin
        logic [127:0] b2b_blk [2];
        logic [127:0] b2b_exp [2];
        int           acc [2];
        int           nacc, nout;
        bit           adv, seen;

        rst_n     = 1'b0;
        in_valid  = 4'b0;
        out_ready = 4'b1111;
        for (int d = 0; d < 4; d++) in_block[d] = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        for (int d = 0; d < 4; d++) check("rst_out_block", out_block[d], '0);
        rst_n = 1'b1;
        #1 check("rel_in_ready", 128'(in_ready), 128'hf);

        run_block(0, C1_IN, C1_OUT, 16, "c1_l1");
        run_block(0, SPOT_IN, SPOT_OUT, 16, "spot_l1");
        run_block(1, C1_IN, C1_OUT, 8, "c1_l2");
        run_block(3, C1_IN, C1_OUT, 1, "c1_l16");
        run_block(3, SPOT_IN, SPOT_OUT, 1, "spot_l16");

        // Backpressure on the LANES=4 instance.
        out_ready[2] = 1'b0;
        run_block(2, C1_IN, C1_OUT, 4, "c1_l4");
        in_valid[2] = 1'b1;
        in_block[2] = SPOT_IN;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid[2]), 128'd1);
            check("bp_out_block", out_block[2], C1_OUT);
            check("bp_in_ready", 128'(in_ready[2]), 128'd0);
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        check("bp_release_in_ready", 128'(in_ready[2]), 128'd1);
        check("bp_release_out_valid", 128'(out_valid[2]), 128'd0);
        check("bp_release_busy", 128'(busy[2]), 128'd0);

        // Reset in the fifth BUSY cycle of the LANES=1 instance.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_block[0] = C1_IN;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        check("mid_rst_out_block", out_block[0], '0);
        check("mid_rst_in_ready", 128'(in_ready[0]), 128'd0);
        check("mid_rst_busy", 128'(busy[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rel_in_ready", 128'(in_ready[0]), 128'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        check("mid_rel_no_out_valid", 128'(seen), 128'd0);

        // Back-to-back random blocks with in_valid held high.
        for (int i = 0; i < 2; i++) begin
            b2b_blk[i] = {$urandom, $urandom, $urandom, $urandom};
            b2b_exp[i] = inv_sub_model(b2b_blk[i]);
        end
        acc[0] = -1; acc[1] = -1;
        nacc = 0; nout = 0; adv = 1'b0;
        in_block[0] = b2b_blk[0];
        in_valid[0] = 1'b1;
        for (int t = 0; t < 80 && nout < 2; t++) begin
            if (adv) begin
                adv = 1'b0;
                if (nacc == 1) in_block[0] = b2b_blk[1];
                else           in_valid[0] = 1'b0;
            end
            if (out_valid[0]) begin
                check("b2b_data", out_block[0], b2b_exp[nout]);
                nout++;
            end
            if (in_valid[0] && in_ready[0] && nacc < 2) begin
                acc[nacc] = t;
                nacc++;
                adv = 1'b1;
            end
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        check("b2b_outputs", 128'(nout), 128'd2);
        check("b2b_spacing", 128'(acc[1] - acc[0]), 128'd18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inv_subbytes_seq.md
# inv_subbytes_seq

Serialized AES inverse SubBytes stage for the decryption datapath. It sits directly downstream of the inverse ShiftRows stage and upstream of AddRoundKey. It accepts one 128-bit state per valid/ready handshake and substitutes LANES bytes per clock through the inverse S-box. It presents the completed state on a held output register until the consumer accepts it.

## Interface
- LANES, default 1: bytes substituted per cycle; legal values 1, 2, 4, 8, 16 (elaboration error otherwise).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_block valid.
- in_ready  output  1  block can accept a new state.
- in_block  input  128  state from inverse ShiftRows. Byte i = bits [127-8i -: 8], column-major (byte 0 = row 0 col 0).
- out_valid  output  1  out_block holds a finished state.
- out_ready  input  1  consumer accepts out_block.
- out_block  output  128  inverse-substituted state, same byte order.
- busy  output  1  high in BUSY and DONE.

## Operation
- States: IDLE, BUSY, DONE. Encoding is 2 bits from the package.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture in_block into src_reg, clear cnt, go to BUSY.
- BUSY:
  - Each cycle, for lane j in 0..LANES-1, byte index k = cnt*LANES + j.
  - Write res_reg byte k = INV_SBOX(src_reg byte k).
  - cnt increments.
  - When cnt == 16/LANES-1, the final write happens and the state goes to DONE.
- DONE:
  - out_valid = 1.
  - out_block = res_reg, held stable while out_valid and !out_ready.
  - On out_ready: go to IDLE.
- Handshakes:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - in_valid while not IDLE is ignored (in_ready = 0). The upstream must hold its data.
  - out_valid never drops without out_ready.
- cnt width: clog2(16/LANES), minimum 1 bit. cnt never wraps past 16/LANES-1.
- When LANES=16, BUSY lasts exactly one cycle.
- Bytes of res_reg not yet written in the current pass keep stale values. They are never visible because out_valid is 0 until DONE.
- Reset (asynchronous, any state, including mid-BUSY or DONE without out_ready):
  - State goes to IDLE; cnt, src_reg, res_reg clear to 0.
  - Outputs while in reset: in_ready = 0, out_valid = 0, busy = 0, out_block = 0.
  - In-flight data is discarded.
  - After rst_n deasserts, the first rising edge sees IDLE with in_ready = 1.

## Timing
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational in→out path.
- Latency:
  - Acceptance at edge E gives out_valid high after edge E + 16/LANES.
  - LANES=1: 16 cycles. LANES=4: 4 cycles.
- Throughput: one block per 16/LANES + 2 cycles when out_ready is tied high (BUSY cycles, one DONE cycle, one IDLE cycle).
- in_ready is not asserted in the same cycle as the DONE handoff. This is a deliberate simplicity choice.
- The inverse S-box is purely combinational, one instance per lane. The critical path is src_reg → mux by cnt → sbox → res_reg.

## Structure
- Shared package aes_pkg holds:
  - AES_BLOCK_W = 128 and AES_NBYTES = 16.
  - State localparams ST_IDLE / ST_BUSY / ST_DONE.
  - Byte-slice helper function for the index convention above.
- Sub-module inv_sbox: 8-bit in, 8-bit out, a 256-entry combinational case table. It is instantiated LANES times with generate.
- Top-level holds the FSM, cnt, src_reg, res_reg and lane muxing.

## Test plan
- Reset check:
  - Stimulus: assert rst_n=0 mid-BUSY (cycle 5 of 16), release.
  - Required: out_valid=0, out_block=0 during reset; in_ready=1 on the first edge after release; no out_valid until a new block is accepted.
- FIPS-197 App. C.1 round 1 vector, LANES=1, out_ready=1:
  - Stimulus: in_block = 7a9f102789d5f50b2beffd9f3dca4ea7.
  - Required: out_block = bd6e7c3df2b5779e0b61216e8b10b689; out_valid exactly 16 cycles after acceptance.
- Table spot checks:
  - Stimulus: in_block bytes 63,7c,00,ff,16, then 11 × 00.
  - Required: out bytes 00,01,52,7d,ff, then 11 × 52.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after DONE.
  - Required: out_block stable, out_valid held, in_ready=0, new in_valid ignored. On out_ready=1: IDLE next cycle.
- Parameter sweep:
  - Stimulus: LANES = 2, 4, 16 with the C.1 vector.
  - Required: identical out_block; latency 8, 4, 1 cycles respectively.
- Back-to-back:
  - Stimulus: two random blocks with in_valid held high.
  - Required: both results match the reference model in order; second acceptance occurs 16/LANES + 2 cycles after the first.
